// File: rtl/cgra_pkg.sv
// -----------------------------------------------------------------------------
// cgra_pkg
// Shared types and constants for the CGRA controller slice.
//   main_fsm_t     : state encoding of the main CGRA controller
//   bs_fsm_t       : state encoding of the bitstream loader (bs_loader)
//   CGRA_BS_WORDS  : default number of 32-bit configuration words per bitstream
//   CGRA_MAX_OUT   : default number of outstanding bitstream memory reads
//   bs_word_addr() : byte address of a configuration word in memory
// -----------------------------------------------------------------------------
package cgra_pkg;

  localparam int CGRA_BS_WORDS = 24;
  localparam int CGRA_MAX_OUT  = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_BS,
    S_RUN,
    S_DONE
  } main_fsm_t;

  typedef enum logic [1:0] {
    S_BS_IDLE,
    S_BS_LOAD,
    S_BS_DRAIN,
    S_BS_DONE
  } bs_fsm_t;

  // Words are 32 bits wide and packed back to back from the base address.
  function automatic logic [31:0] bs_word_addr(input logic [31:0] base,
                                               input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/bs_loader.sv
// -----------------------------------------------------------------------------
// bs_loader
// Fetches a configuration bitstream of BS_WORDS 32-bit words from memory over
// an OBI-style req/gnt/rvalid read port and streams each returned word into
// the configuration array. Up to MAX_OUT reads may be in flight; responses
// return in order. An abort stops issuing reads and drains the reads already
// in flight without writing them.
//
// Parameters
//   BS_WORDS     : configuration words per bitstream
//   MAX_OUT      : maximum outstanding memory reads (1..4)
// Ports
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset
//   load_i       : start a load (only honoured while idle)
//   bs_addr_i    : bitstream base byte address, captured with load_i
//   abort_i      : abandon the current load (only honoured while loading)
//   mem_req_o    : read request
//   mem_addr_o   : read byte address (base + 4*words requested so far)
//   mem_gnt_i    : read request accepted
//   mem_rvalid_i : read data valid
//   mem_rdata_i  : read data
//   cfg_we_o     : configuration word write strobe
//   cfg_idx_o    : configuration word index
//   cfg_data_o   : configuration word
//   bs_done_o    : one-cycle pulse when a load completes
//   busy_o       : high whenever the loader is not idle
// -----------------------------------------------------------------------------
module bs_loader
  import cgra_pkg::*;
#(
  parameter int BS_WORDS = CGRA_BS_WORDS,
  parameter int MAX_OUT  = CGRA_MAX_OUT
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        load_i,
  input  logic [31:0]                 bs_addr_i,
  input  logic                        abort_i,
  output logic                        mem_req_o,
  output logic [31:0]                 mem_addr_o,
  input  logic                        mem_gnt_i,
  input  logic                        mem_rvalid_i,
  input  logic [31:0]                 mem_rdata_i,
  output logic                        cfg_we_o,
  output logic [$clog2(BS_WORDS)-1:0] cfg_idx_o,
  output logic [31:0]                 cfg_data_o,
  output logic                        bs_done_o,
  output logic                        busy_o
);

  // Counters must be able to hold the terminal value BS_WORDS itself.
  localparam int CW = $clog2(BS_WORDS + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int IW = $clog2(BS_WORDS);

  localparam logic [CW-1:0] WORDS_C = CW'(BS_WORDS);
  localparam logic [CW-1:0] LAST_C  = CW'(BS_WORDS - 1);
  localparam logic [OW-1:0] MAX_C   = OW'(MAX_OUT);

  bs_fsm_t       state_q, state_d;
  logic [31:0]   base_q;
  logic [CW-1:0] req_cnt_q;
  logic [CW-1:0] resp_cnt_q;
  logic [OW-1:0] out_q, out_d;
  logic          start;
  logic          grant;
  logic          rsp_ok;

  assign mem_addr_o = bs_word_addr(base_q, 32'(req_cnt_q));

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    start      = 1'b0;
    grant      = 1'b0;
    mem_req_o  = 1'b0;
    cfg_we_o   = 1'b0;
    cfg_idx_o  = '0;
    cfg_data_o = '0;
    bs_done_o  = 1'b0;
    busy_o     = (state_q != S_BS_IDLE);

    // A response with nothing in flight cannot belong to this load (e.g. it
    // was issued before a reset), so it is dropped and never underflows.
    rsp_ok = mem_rvalid_i && (out_q != '0);

    // abort_i gates the request combinationally so no new read is granted in
    // the abort cycle; req_cnt never passes BS_WORDS because of the limit.
    if (state_q == S_BS_LOAD) begin
      mem_req_o = !abort_i && (req_cnt_q < WORDS_C) && (out_q < MAX_C);
      cfg_we_o  = rsp_ok;
    end

    if (cfg_we_o) begin
      cfg_idx_o  = resp_cnt_q[IW-1:0];
      cfg_data_o = mem_rdata_i;
    end

    grant = mem_req_o && mem_gnt_i;

    // Grant and response in the same cycle cancel out.
    if (grant && !rsp_ok) begin
      out_d = out_q + OW'(1);
    end else if (!grant && rsp_ok) begin
      out_d = out_q - OW'(1);
    end

    unique case (state_q)
      S_BS_IDLE: begin
        if (load_i) begin
          start   = 1'b1;
          state_d = S_BS_LOAD;
        end
      end
      S_BS_LOAD: begin
        // Abort wins over completion; the final word is still written above.
        if (abort_i) begin
          state_d = (out_d == '0) ? S_BS_IDLE : S_BS_DRAIN;
        end else if (cfg_we_o && (resp_cnt_q == LAST_C)) begin
          state_d = S_BS_DONE;
        end
      end
      S_BS_DRAIN: begin
        if (out_d == '0) begin
          state_d = S_BS_IDLE;
        end
      end
      S_BS_DONE: begin
        bs_done_o = 1'b1;
        state_d   = S_BS_IDLE;
      end
      default: begin
        state_d = S_BS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_BS_IDLE;
      base_q     <= '0;
      req_cnt_q  <= '0;
      resp_cnt_q <= '0;
      out_q      <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        base_q     <= bs_addr_i;
        req_cnt_q  <= '0;
        resp_cnt_q <= '0;
        out_q      <= '0;
      end else begin
        if (grant) begin
          req_cnt_q <= req_cnt_q + CW'(1);
        end
        if (cfg_we_o) begin
          resp_cnt_q <= resp_cnt_q + CW'(1);
        end
        out_q <= out_d;
      end
    end
  end

endmodule

// File: doc/bs_loader.md
BS_LOADER -- requirements
Module: bs_loader

Interface
REQ-001 SHALL have parameter BS_WORDS, default 24: number of 32-bit configuration words per bitstream.
REQ-002 SHALL have parameter MAX_OUT, default 2: maximum outstanding memory reads, range 1..4.
REQ-003 SHALL have port clk_i  input  1  clock.
REQ-004 SHALL have port rst_ni  input  1  reset: asynchronous, active-low.
REQ-005 SHALL have port load_i  input  1  start-load pulse; sampled only in S_BS_IDLE.
REQ-006 SHALL have port bs_addr_i  input  32  bitstream base byte address, captured with load_i.
REQ-007 SHALL have port abort_i  input  1  abort load; same role as clear_bs in the main controller.
REQ-008 SHALL have port mem_req_o  output  1  read request.
REQ-009 SHALL have port mem_addr_o  output  32  read byte address.
REQ-010 SHALL have port mem_gnt_i  input  1  request accepted.
REQ-011 SHALL have port mem_rvalid_i  input  1  read data valid.
REQ-012 SHALL have port mem_rdata_i  input  32  read data.
REQ-013 SHALL have port cfg_we_o  output  1  configuration write strobe.
REQ-014 SHALL have port cfg_idx_o  output  $clog2(BS_WORDS)  configuration word index.
REQ-015 SHALL have port cfg_data_o  output  32  configuration word.
REQ-016 SHALL have port bs_done_o  output  1  one-cycle pulse when load completes; drives bs_done of the main controller.
REQ-017 SHALL have port busy_o  output  1  high in every state except S_BS_IDLE.

Function
REQ-018 SHALL implement FSM states S_BS_IDLE, S_BS_LOAD, S_BS_DRAIN, S_BS_DONE.
REQ-019 S_BS_IDLE: on load_i, SHALL capture bs_addr_i, clear req/resp counters and outstanding count, and go to S_BS_LOAD next cycle.
REQ-020 S_BS_LOAD: SHALL assert mem_req_o while req_cnt < BS_WORDS and outstanding < MAX_OUT.
REQ-021 mem_addr_o SHALL equal base + 4*req_cnt and SHALL remain stable while mem_req_o is high without mem_gnt_i.
REQ-022 A grant (mem_req_o & mem_gnt_i) SHALL increment req_cnt and the outstanding count.
REQ-023 mem_rvalid_i SHALL decrement the outstanding count; a grant and rvalid in the same cycle SHALL leave the count unchanged.
REQ-024 Each mem_rvalid_i in S_BS_LOAD SHALL produce cfg_we_o=1 in the same cycle, with cfg_data_o=mem_rdata_i and cfg_idx_o=resp_cnt, then increment resp_cnt.
REQ-025 The cycle where resp_cnt reaches BS_WORDS SHALL transition S_BS_LOAD to S_BS_DONE.
REQ-026 S_BS_DONE SHALL last exactly one cycle with bs_done_o=1, then return to S_BS_IDLE.
REQ-027 abort_i in S_BS_LOAD SHALL immediately deassert mem_req_o and go to S_BS_DRAIN next cycle.
REQ-028 If outstanding is 0 at abort, S_BS_LOAD SHALL go directly to S_BS_IDLE.
REQ-029 S_BS_DRAIN SHALL discard responses (cfg_we_o=0) until outstanding reaches 0, then go to S_BS_IDLE without bs_done_o.
REQ-030 abort_i in S_BS_IDLE, S_BS_DONE or S_BS_DRAIN SHALL be ignored.
REQ-031 abort_i and the final response in the same cycle SHALL take abort priority: the final word is still written, but there is no bs_done_o and the next state is S_BS_IDLE.
REQ-032 mem_rvalid_i while outstanding is 0 SHALL be ignored and SHALL NOT make the counter underflow.
REQ-033 load_i outside S_BS_IDLE SHALL be ignored.
REQ-034 Counters SHALL saturate-free wrap-protect: req_cnt is never granted beyond BS_WORDS.

Reset
REQ-035 On rst_ni low, SHALL set the state to S_BS_IDLE and clear base, req_cnt, resp_cnt and outstanding.
REQ-036 During reset, SHALL hold mem_req_o, cfg_we_o, bs_done_o and busy_o at 0, and mem_addr_o, cfg_idx_o and cfg_data_o at 0.
REQ-037 Reset mid-load SHALL abandon the load; late responses arriving after reset SHALL be ignored per REQ-032.

Structure
REQ-038 bs_fsm_t (4-state enum) and the BS_WORDS default constant SHALL live in cgra_pkg, next to main_fsm_t.
REQ-039 SHALL be a single module with no sub-module; memory port signals SHALL follow the OBI req/gnt/rvalid subset.

Verification
REQ-040 Verification SHALL cover a normal load: BS_WORDS=4, gnt always 1, rvalid one cycle after gnt, base 0x1000 -> addresses 0x1000/04/08/0C; cfg_idx 0..3 with matching data; one bs_done_o pulse.
REQ-041 Verification SHALL cover backpressure: gnt low for 3 cycles on the second request -> mem_addr_o held at 0x1004 with req high; outstanding never exceeds MAX_OUT=2.
REQ-042 Verification SHALL cover abort with 2 outstanding: abort_i in S_BS_LOAD -> mem_req_o drops the same cycle; 2 responses drained with cfg_we_o=0; return to IDLE with no bs_done_o.
REQ-043 Verification SHALL cover abort on the last response: abort_i together with the 4th rvalid -> cfg_we_o=1 with idx 3; no bs_done_o; IDLE next cycle.
REQ-044 Verification SHALL cover spurious events: rvalid in IDLE and load_i during LOAD -> no cfg_we_o, no restart, counters unchanged.
REQ-045 Verification SHALL cover reset mid-load: rst_ni low after 2 grants -> all outputs 0; a subsequent load from 0x2000 completes normally.
